// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing and frame-length constants.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_BITS        = 8;
    localparam int START_BITS       = 1;
    localparam int FRAME_BITS_8N1   = START_BITS + DATA_BITS + 1;

    function automatic int frame_bits(input int parity_en, input int stop_bits);
        return START_BITS + DATA_BITS + parity_en + stop_bits;
    endfunction

    // Even parity is the XOR of the byte; odd parity inverts it.
    function automatic logic parity_of(input logic [7:0] b, input logic odd);
        return (^b) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit timer: counts clk cycles within one serial bit and strobes the last (and next-to-last) cycle.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end,
    output logic bit_near_end
);

    localparam int CW = 16;

    logic [CW-1:0] count;

    assign bit_end      = (count == CW'(CLKS_PER_BIT - 1));
    assign bit_near_end = (count == CW'(CLKS_PER_BIT - 2));

    // The only way back to zero is the explicit reload; the counter never runs past the last cycle.
    always_ff @(posedge clk) begin
        if (rst || restart || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmit.sv
// UART transmitter: valid/ready byte input, LSB-first serial frame with optional parity and 1 or 2 stop bits.
module uart_transmit
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       out,
    output logic       done
);

    uart_state_t state;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic        parity_bit;
    logic        bit_end;
    logic        bit_near_end;
    logic        restart;
    logic        last_stop;

    // Holding the timer in reload while idle makes the start bit exactly one full bit long.
    assign restart   = (state == ST_IDLE);
    assign ready     = (state == ST_IDLE) && !rst;
    assign last_stop = (STOP_BITS == 2) ? stop_idx : 1'b1;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk         (clk),
        .rst         (rst),
        .restart     (restart),
        .bit_end     (bit_end),
        .bit_near_end(bit_near_end)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            out        <= 1'b1;
            done       <= 1'b0;
            shift_reg  <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            parity_bit <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    out <= 1'b1;
                    if (valid) begin
                        shift_reg  <= data;
                        parity_bit <= parity_of(data, PARITY_ODD != 0);
                        bit_idx    <= '0;
                        stop_idx   <= 1'b0;
                        out        <= 1'b0;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        out   <= shift_reg[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                out   <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                out   <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            out     <= shift_reg[bit_idx + 3'd1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        out   <= 1'b1;
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // done is registered, so it is raised one cycle early to land on the final stop cycle.
                    if (bit_near_end && last_stop) begin
                        done <= 1'b1;
                    end
                    if (bit_end) begin
                        if (last_stop) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    out   <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit: 8N1, even/odd parity, two stop bits, back-to-back, mid-frame reset, loopback.
module tb_uart_transmit;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] data_v  [4];
    logic       valid_v [4];
    logic       ready0, ready1, ready2, ready3;
    logic       out0, out1, out2, out3;
    logic       done0, done1, done2, done3;

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;

    logic out_s, done_s, ready_s;
    logic rec_out   [400];
    logic rec_done  [400];
    logic rec_ready [400];

    uart_transmit #(.CLKS_PER_BIT(16)) dut0 (
        .clk(clk), .rst(rst), .data(data_v[0]), .valid(valid_v[0]),
        .ready(ready0), .out(out0), .done(done0)
    );
    uart_transmit #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .data(data_v[1]), .valid(valid_v[1]),
        .ready(ready1), .out(out1), .done(done1)
    );
    uart_transmit #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .rst(rst), .data(data_v[2]), .valid(valid_v[2]),
        .ready(ready2), .out(out2), .done(done2)
    );
    uart_transmit #(.CLKS_PER_BIT(16), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .data(data_v[3]), .valid(valid_v[3]),
        .ready(ready3), .out(out3), .done(done3)
    );

    always_comb begin
        out_s   = out0;
        done_s  = done0;
        ready_s = ready0;
        case (sel)
            1: begin out_s = out1; done_s = done1; ready_s = ready1; end
            2: begin out_s = out2; done_s = done2; ready_s = ready2; end
            3: begin out_s = out3; done_s = done3; ready_s = ready3; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic record(input int i);
        rec_out[i]   = out_s;
        rec_done[i]  = done_s;
        rec_ready[i] = ready_s;
    endtask

    // One idle cycle, then handshake a byte and record n cycles starting at the first start-bit cycle.
    task automatic run_frame(input int s, input logic [7:0] b, input int n);
        sel = s;
        @(negedge clk);
        data_v[s]  = b;
        valid_v[s] = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) valid_v[s] = 1'b0;
            record(i);
        end
    endtask

    function automatic logic [15:0] bits_at(input int off, input int nbits);
        logic [15:0] v = '0;
        for (int b = 0; b < nbits; b++) v[b] = rec_out[off + b*16 + 8];
        return v;
    endfunction

    function automatic int glitches(input int off, input int nbits);
        int g = 0;
        for (int i = 0; i < nbits*16; i++)
            if (rec_out[off + i] !== rec_out[off + (i/16)*16]) g++;
        return g;
    endfunction

    function automatic int first_done(input int n);
        for (int i = 0; i < n; i++) if (rec_done[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_done(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (rec_done[i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_ready(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (rec_ready[i] !== 1'b0) c++;
        return c;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int errs;
        logic [7:0]  b;
        logic [15:0] fb;

        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_v[k]  = 8'h00;
            valid_v[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_out",   out0,   1'b1);
        check("rst_ready", ready0, 1'b0);
        check("rst_done",  done0,  1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", ready0, 1'b1);

        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (out0 !== 1'b1) cnt++;
        end
        check("idle_out_low", cnt, 0);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        run_frame(0, 8'hA5, 160);
        check("a5_bits",     bits_at(0, 10), 16'b0000_0011_0100_1010);
        check("a5_glitch",   glitches(0, 10), 0);
        check("a5_done_at",  first_done(160), 159);
        check("a5_done_cnt", count_done(160), 1);
        check("a5_busy_rdy", count_ready(160), 0);
        @(negedge clk);
        check("a5_idle_out", out0, 1'b1);
        check("a5_idle_rdy", ready0, 1'b1);

        // 0x07 has three ones: even parity bit 1, odd parity bit 0
        run_frame(1, 8'h07, 176);
        check("even_bits",    bits_at(0, 11), {5'd0, 1'b1, 1'b1, 8'h07, 1'b0});
        check("even_glitch",  glitches(0, 11), 0);
        check("even_done_at", first_done(176), 175);
        run_frame(2, 8'h07, 176);
        check("odd_bits",     bits_at(0, 11), {5'd0, 1'b1, 1'b0, 8'h07, 1'b0});
        check("odd_done_at",  first_done(176), 175);
        run_frame(3, 8'h81, 176);
        check("stop2_bits",    bits_at(0, 11), {5'd0, 1'b1, 1'b1, 8'h81, 1'b0});
        check("stop2_done_at", first_done(176), 175);
        check("stop2_dn_cnt",  count_done(176), 1);

        // Back-to-back with valid held; data wiggles mid-frame must not disturb the latched byte.
        sel = 0;
        @(negedge clk);
        data_v[0]  = 8'h00;
        valid_v[0] = 1'b1;
        for (int i = 0; i < 321; i++) begin
            @(negedge clk);
            if (i == 50)  data_v[0]  = 8'h5A;
            if (i == 150) data_v[0]  = 8'hFF;
            if (i == 161) valid_v[0] = 1'b0;
            record(i);
        end
        check("b2b_first",    bits_at(0, 10), {6'd0, 1'b1, 8'h00, 1'b0});
        check("b2b_gap_out",  rec_out[160], 1'b1);
        check("b2b_gap_rdy",  rec_ready[160], 1'b1);
        check("b2b_second",   bits_at(161, 10), {6'd0, 1'b1, 8'hFF, 1'b0});
        check("b2b_glitch",   glitches(0, 10) + glitches(161, 10), 0);
        check("b2b_done_cnt", count_done(321), 2);
        check("b2b_done2",    rec_done[320], 1'b1);

        // Reset 50 cycles into a frame.
        run_frame(0, 8'h96, 51);
        rst = 1'b1;
        @(negedge clk);
        check("abort_out",  out0,   1'b1);
        check("abort_rdy",  ready0, 1'b0);
        check("abort_done", done0,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_rel_rdy", ready0, 1'b1);
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (done0 !== 1'b0 || out0 !== 1'b1) cnt++;
        end
        check("abort_quiet", cnt, 0);
        run_frame(0, 8'h3C, 160);
        check("after_abort_bits", bits_at(0, 10), {6'd0, 1'b1, 8'h3C, 1'b0});
        check("after_abort_done", first_done(160), 159);

        // Loopback through a mid-bit sampling receiver model.
        errs = 0;
        for (int k = 0; k < 256; k++) begin
            b = 8'($urandom);
            run_frame(0, b, 160);
            fb = bits_at(0, 10);
            if (fb[0] !== 1'b0 || fb[9] !== 1'b1 || glitches(0, 10) != 0) errs++;
            check($sformatf("loop_byte_%0d", k), fb[8:1], b);
        end
        check("loop_frame_err", errs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
